// File: rtl/bnn_ctrl_pkg.sv
// Shared constants and types for the BNN frame controller: opcodes, frame size,
// error-bit positions and the frame FSM state encoding.
package bnn_ctrl_pkg;

  localparam int IMG_BYTE_COUNT = 113;
  localparam int BYTE_TIMEOUT   = 20000;
  localparam int RESULT_W       = 4;
  localparam int IDX_W          = 7;

  localparam logic [7:0] OP_LOAD  = 8'hA1;
  localparam logic [7:0] OP_START = 8'hA2;
  localparam logic [7:0] OP_CLEAR = 8'hA3;

  localparam int ERR_BAD_CMD  = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_BUSY     = 2;
  localparam int ERR_CHECKSUM = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_BYTE_COUNT - 1);
  // Index value at which the trailing checksum byte is expected.
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(IMG_BYTE_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_INFER = 2'd2,
    ST_DONE  = 2'd3
  } frame_state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_LOAD) || (b == OP_START) || (b == OP_CLEAR);
  endfunction

endpackage

// File: rtl/bnn_frame_controller_byte_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th idle cycle completes.
module byte_gap_timer #(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count saturates at the expiry point; the owner leaves the waiting state anyway.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bnn_frame_controller.sv
// Command/frame sequencer between the SPI byte receiver and the BNN core.
// Optional trailing-XOR image checksum is enabled by defining IMG_CHECKSUM_EN.
module bnn_frame_controller
  import bnn_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          spi_rx_data,
  input  logic                spi_byte_valid,
  output logic                byte_taken,
  output logic                rx_enable,
  output logic                img_wr_en,
  output logic [IDX_W-1:0]    img_wr_addr,
  output logic [7:0]          img_wr_data,
  output logic                bnn_start,
  input  logic                bnn_done,
  input  logic [RESULT_W-1:0] bnn_result,
  output logic [RESULT_W-1:0] result_digit,
  output logic                result_valid,
  output logic                img_loaded,
  output logic [3:0]          err_flags,
  output frame_state_t        fsm_state
);

  frame_state_t     state;
  frame_state_t     state_next;
  logic [IDX_W-1:0] idx;
  logic [3:0]       err_q;

  logic cmd_byte;
  logic op_load;
  logic op_start;
  logic op_clear;
  logic op_bad;
  logic start_ok;
  logic start_refused;
  logic load_byte;
  logic payload_byte;
  logic load_end;
  logic load_good;
  logic busy_drop;
  logic infer_done;
  logic gap_clear;
  logic gap_enable;
  logic gap_expired;
  logic timeout;

  // Handshake: spi_byte_valid is a one-cycle offer with no backpressure; the byte
  // is consumed exactly when byte_taken is high in that same cycle, otherwise lost.
  assign cmd_byte      = byte_taken && (state == ST_IDLE);
  assign op_load       = cmd_byte && (spi_rx_data == OP_LOAD);
  assign op_start      = cmd_byte && (spi_rx_data == OP_START);
  assign op_clear      = cmd_byte && (spi_rx_data == OP_CLEAR);
  assign op_bad        = cmd_byte && !is_opcode(spi_rx_data);
  assign start_ok      = op_start && img_loaded;
  assign start_refused = op_start && !img_loaded;
  assign load_byte     = byte_taken && (state == ST_LOAD);
  assign busy_drop     = spi_byte_valid && ((state == ST_INFER) || (state == ST_DONE));
  assign infer_done    = (state == ST_INFER) && bnn_done;

`ifdef IMG_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst || op_load) begin
      csum <= '0;
    end else if (payload_byte) begin
      csum <= csum ^ spi_rx_data;
    end
  end

  assign payload_byte = load_byte && (idx != CSUM_IDX);
  assign load_end     = load_byte && (idx == CSUM_IDX);
  assign load_good    = (spi_rx_data == csum);
`else
  assign payload_byte = load_byte;
  assign load_end     = load_byte && (idx == LAST_IDX);
  assign load_good    = 1'b1;
`endif

  // An accepted byte clears the gap counter in the same cycle, so it beats expiry.
  assign gap_enable = (state == ST_LOAD);
  assign gap_clear  = byte_taken || (state != ST_LOAD);
  assign timeout    = gap_expired && !byte_taken;

  byte_gap_timer #(
    .TIMEOUT (BYTE_TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .expired (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (op_load) begin
          state_next = ST_LOAD;
        end else if (start_ok) begin
          state_next = ST_INFER;
        end
      end
      ST_LOAD: begin
        if (load_end || timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_INFER: begin
        if (bnn_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_enable  = (state == ST_IDLE) || (state == ST_LOAD);
    byte_taken = spi_byte_valid && rx_enable;
    fsm_state  = state;
    err_flags  = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      img_wr_en    <= 1'b0;
      img_wr_addr  <= '0;
      img_wr_data  <= '0;
      bnn_start    <= 1'b0;
      result_digit <= '0;
      result_valid <= 1'b0;
      img_loaded   <= 1'b0;
      err_q        <= '0;
    end else begin
      img_wr_en <= payload_byte;
      bnn_start <= start_ok;

      if (payload_byte) begin
        img_wr_addr <= idx;
        img_wr_data <= spi_rx_data;
        idx         <= idx + IDX_W'(1);
      end

      if (op_load) begin
        idx          <= '0;
        img_loaded   <= 1'b0;
        result_valid <= 1'b0;
      end

      if (timeout) begin
        idx                <= '0;
        img_loaded         <= 1'b0;
        err_q[ERR_TIMEOUT] <= 1'b1;
      end

      if (load_end) begin
        img_loaded <= load_good;
        if (!load_good) begin
          err_q[ERR_CHECKSUM] <= 1'b1;
        end
      end

      if (op_bad || start_refused) begin
        err_q[ERR_BAD_CMD] <= 1'b1;
      end

      if (busy_drop) begin
        err_q[ERR_BUSY] <= 1'b1;
      end

      if (op_clear) begin
        err_q        <= '0;
        img_loaded   <= 1'b0;
        result_valid <= 1'b0;
      end

      if (infer_done) begin
        result_digit <= bnn_result;
        result_valid <= 1'b1;
      end
    end
  end

endmodule
